// File: rtl/lamp_ctrl_n.sv
// lamp_ctrl_n
//
// Multi-switch lamp controller. One lamp is driven from N_SW wall switches,
// and flipping any single switch toggles the lamp. Each raw switch level is
// brought into the clock domain by a two-flop synchroniser and then debounced
// on its own channel. An optional idle timer turns the lamp off after TIMEOUT
// cycles with no switch activity while the lamp is on.
//
// Parameters
//   N_SW      : number of switch channels (1..16)
//   DB_CYCLES : consecutive mismatch cycles needed to accept a change (>=1)
//   TIMEOUT   : idle cycles with the lamp on before auto-off, 0 disables
//
// Ports
//   clk    : single clock, all state updates on the rising edge
//   rst    : synchronous active-high reset
//   sw     : raw, asynchronous, bouncy switch levels
//   F      : lamp on (1) / off (0), registered
//   sw_db  : debounced switch levels, registered
//   chg    : one-cycle pulse after F toggled because of a switch change
//   tout   : one-cycle pulse after F was cleared by the idle timer
//
// All outputs come straight from flops, so there is no combinational path
// from sw to any output.

module lamp_ctrl_n #(
    parameter int N_SW      = 3,
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw,
    output logic            F,
    output logic [N_SW-1:0] sw_db,
    output logic            chg,
    output logic            tout
);

    // Debounce counter only has to reach DB_CYCLES-1; keep at least one bit
    // so DB_CYCLES=1 still elaborates cleanly.
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] CNT_LAST = DBW'(DB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser per channel (s1 then s2)
    // ------------------------------------------------------------------
    logic [N_SW-1:0] s1_q;
    logic [N_SW-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw;
            s2_q <= s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce
    // ------------------------------------------------------------------
    logic [N_SW-1:0] db_q;
    logic [N_SW-1:0] db_d;
    logic [DBW-1:0]  cnt_q [N_SW];
    logic [DBW-1:0]  cnt_d [N_SW];

    // Any agreement between s2 and the debounced level restarts the count,
    // so a bounce shorter than DB_CYCLES never reaches sw_db.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Change detection
    // ------------------------------------------------------------------
    logic [N_SW-1:0] changed;
    logic            activity;
    logic            odd_change;

    // An odd number of simultaneous changes flips the lamp; an even number
    // cancels out but still counts as activity for the idle timer.
    assign changed    = db_d ^ db_q;
    assign activity   = |changed;
    assign odd_change = ^changed;

    // ------------------------------------------------------------------
    // Idle timer
    // ------------------------------------------------------------------
    logic f_q;
    logic expire;

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int TW = $clog2(TIMEOUT + 1);
            localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

            logic [TW-1:0] tmr_q;
            logic [TW-1:0] tmr_d;
            logic          tmr_hit;

            // Counting only happens while the lamp is on and the switches are
            // quiet; activity always reloads, so activity beats expiry.
            always_comb begin
                tmr_d   = '0;
                tmr_hit = 1'b0;
                if (f_q && !activity) begin
                    if (tmr_q == TMR_LAST) begin
                        tmr_hit = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    tmr_q <= '0;
                end else begin
                    tmr_q <= tmr_d;
                end
            end

            assign expire = tmr_hit;
        end else begin : g_no_timer
            assign expire = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lamp state and event pulses
    // ------------------------------------------------------------------
    logic f_d;
    logic chg_q;
    logic chg_d;
    logic tout_q;
    logic tout_d;

    always_comb begin
        f_d    = f_q;
        chg_d  = 1'b0;
        tout_d = 1'b0;
        if (activity) begin
            f_d   = f_q ^ odd_change;
            chg_d = odd_change;
        end else if (expire) begin
            f_d    = 1'b0;
            tout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q    <= 1'b0;
            chg_q  <= 1'b0;
            tout_q <= 1'b0;
        end else begin
            f_q    <= f_d;
            chg_q  <= chg_d;
            tout_q <= tout_d;
        end
    end

    assign F     = f_q;
    assign sw_db = db_q;
    assign chg   = chg_q;
    assign tout  = tout_q;

endmodule

// File: tb/tb_lamp_ctrl_n.sv
module tb_lamp_ctrl_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw_t;
    logic [2:0] sw_n;

    logic       f_t, chg_t, tout_t;
    logic [2:0] db_t;
    logic       f_n, chg_n, tout_n;
    logic [2:0] db_n;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        bit         dut;   // 0: TIMEOUT=16 instance, 1: TIMEOUT=0 instance
        logic [5:0] exp;   // {F, sw_db[2:0], chg, tout}
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    localparam bit T = 1'b0;
    localparam bit N = 1'b1;

    lamp_ctrl_n #(.N_SW(3), .DB_CYCLES(4), .TIMEOUT(16)) u_dut_t (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw_t),
        .F     (f_t),
        .sw_db (db_t),
        .chg   (chg_t),
        .tout  (tout_t)
    );

    lamp_ctrl_n #(.N_SW(3), .DB_CYCLES(4), .TIMEOUT(0)) u_dut_n (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw_n),
        .F     (f_n),
        .sw_db (db_n),
        .chg   (chg_n),
        .tout  (tout_n)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] observe(input bit dut);
        if (dut == N) return {f_n, db_n, chg_n, tout_n};
        return {f_t, db_t, chg_t, tout_t};
    endfunction

    task automatic cmp(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @cyc %0d: F/db/chg/tout observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int due, input bit dut, input logic f, input logic [2:0] db,
                        input logic c, input logic to, input string tag);
        exp_t e;
        e.due = due;
        e.dut = dut;
        e.exp = {f, db, c, to};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic service();
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due == cyc) begin
                cmp(tag_q[i], observe(exp_q[i].dut), exp_q[i].exp);
                exp_q.delete(i);
                tag_q.delete(i);
            end
        end
    endtask

    // One rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        service();
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        int         c;
        int         e;
        int         a;
        logic [2:0] prev;
        logic [2:0] v;

        rst  = 1'b1;
        sw_t = 3'b000;
        sw_n = 3'b000;
        tick();
        tick();
        cmp("reset_t", observe(T), 6'b0);
        cmp("reset_n", observe(N), 6'b0);
        rst = 1'b0;

        // Reset in the middle of a debounce discards the progress.
        c = cyc;
        sw_t = 3'b001;
        wait_to(c + 4);
        cmp("predb_t", observe(T), 6'b0);
        rst = 1'b1;
        tick();
        cmp("rst_mid_t", observe(T), 6'b0);
        rst = 1'b0;

        // sw_t held high through reset is seen as a fresh change.
        c = cyc;
        push(c + 5, T, 1'b0, 3'b000, 1'b0, 1'b0, "rst_lat_pre");
        push(c + 6, T, 1'b1, 3'b001, 1'b1, 1'b0, "rst_lat_on");
        push(c + 7, T, 1'b1, 3'b001, 1'b0, 1'b0, "chg_1cyc");
        e = c + 6;
        push(e + 15, T, 1'b1, 3'b001, 1'b0, 1'b0, "tmr_pre");
        push(e + 16, T, 1'b0, 3'b001, 1'b0, 1'b1, "tmr_off");
        push(e + 17, T, 1'b0, 3'b001, 1'b0, 1'b0, "tout_1cyc");
        wait_to(e + 17);

        // Next odd change after auto-off turns the lamp back on.
        c = cyc;
        sw_t = 3'b011;
        push(c + 5, T, 1'b0, 3'b001, 1'b0, 1'b0, "reon_pre");
        push(c + 6, T, 1'b1, 3'b011, 1'b1, 1'b0, "reon_chg");
        e = c + 6;

        // Race: switch change lands on the expiry edge e+16.
        wait_to(e + 10);
        c = cyc;
        sw_t = 3'b111;
        push(c + 5,  T, 1'b1, 3'b011, 1'b0, 1'b0, "race_pre");
        push(c + 6,  T, 1'b0, 3'b111, 1'b1, 1'b0, "race_tog");
        push(c + 7,  T, 1'b0, 3'b111, 1'b0, 1'b0, "race_after");
        push(c + 25, T, 1'b0, 3'b111, 1'b0, 1'b0, "race_quiet");
        wait_to(c + 26);

        // Two channels change together: lamp holds, no chg.
        c = cyc;
        sw_t = 3'b100;
        push(c + 5, T, 1'b0, 3'b111, 1'b0, 1'b0, "sim_pre");
        push(c + 6, T, 1'b0, 3'b100, 1'b0, 1'b0, "sim_hold");
        push(c + 7, T, 1'b0, 3'b100, 1'b0, 1'b0, "sim_nochg");
        wait_to(c + 10);

        // Even change while on reloads the idle timer.
        c = cyc;
        sw_t = 3'b110;
        push(c + 6, T, 1'b1, 3'b110, 1'b1, 1'b0, "on_again");
        e = c + 6;
        wait_to(e + 4);
        c = cyc;
        sw_t = 3'b000;
        a = c + 6;
        push(a,      T, 1'b1, 3'b000, 1'b0, 1'b0, "even_hold");
        push(e + 16, T, 1'b1, 3'b000, 1'b0, 1'b0, "reload_no_exp");
        push(a + 15, T, 1'b1, 3'b000, 1'b0, 1'b0, "reload_pre");
        push(a + 16, T, 1'b0, 3'b000, 1'b0, 1'b1, "reload_exp");
        push(a + 17, T, 1'b0, 3'b000, 1'b0, 1'b0, "reload_after");
        wait_to(a + 18);

        // Bounce of 3 cycles is rejected.
        c = cyc;
        sw_n = 3'b001;
        wait_to(c + 3);
        sw_n = 3'b000;
        push(c + 5,  N, 1'b0, 3'b000, 1'b0, 1'b0, "b3_a");
        push(c + 6,  N, 1'b0, 3'b000, 1'b0, 1'b0, "b3_b");
        push(c + 7,  N, 1'b0, 3'b000, 1'b0, 1'b0, "b3_c");
        push(c + 12, N, 1'b0, 3'b000, 1'b0, 1'b0, "b3_d");
        wait_to(c + 15);

        // Pulse of 4 cycles is accepted, and its release is accepted too.
        c = cyc;
        sw_n = 3'b001;
        wait_to(c + 4);
        sw_n = 3'b000;
        push(c + 5,  N, 1'b0, 3'b000, 1'b0, 1'b0, "b4_pre");
        push(c + 6,  N, 1'b1, 3'b001, 1'b1, 1'b0, "b4_on");
        push(c + 7,  N, 1'b1, 3'b001, 1'b0, 1'b0, "b4_chg_end");
        push(c + 9,  N, 1'b1, 3'b001, 1'b0, 1'b0, "b4_hold");
        push(c + 10, N, 1'b0, 3'b000, 1'b1, 1'b0, "b4_off");
        push(c + 11, N, 1'b0, 3'b000, 1'b0, 1'b0, "b4_settle");
        wait_to(c + 15);

        // XOR sweep with the timer disabled: 1..7 then back to 0.
        prev = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            v = 3'(k);
            c = cyc;
            sw_n = v;
            push(c + 5,  N, ^prev, prev, 1'b0, 1'b0, $sformatf("xor%0d_pre", k));
            push(c + 6,  N, ^v, v, (^v) ^ (^prev), 1'b0, $sformatf("xor%0d_upd", k));
            push(c + 7,  N, ^v, v, 1'b0, 1'b0, $sformatf("xor%0d_post", k));
            push(c + 19, N, ^v, v, 1'b0, 1'b0, $sformatf("xor%0d_hold", k));
            wait_to(c + 20);
            prev = v;
        end

        wait_to(cyc + 5);
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
